diff_freq_frame_encoder: RTL and testbench



---
 rtl/diff_freq_pkg.sv | 42 ++++
 rtl/frame_byte_sel.sv | 19 +
 rtl/diff_freq_frame_encoder.sv | 109 ++++++++++
 tb/tb_diff_freq_frame_encoder.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/diff_freq_pkg.sv
// Shared definitions for the differential-frequency frame encoder and decoder.
// Frame length grows by two period bytes when PERIOD_FIELD_EN is defined.
package diff_freq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int SEL_LSB   = 0;
  localparam int SEL_W     = 4;
  localparam int START_BIT = 4;
  localparam int STOP_BIT  = 5;
  localparam int MODE_BIT  = 6;

`ifdef PERIOD_FIELD_EN
  localparam int PERIOD_BYTES = 2;
`else
  localparam int PERIOD_BYTES = 0;
`endif

  // Output pattern bytes + frequency pattern bytes + control byte (+ periods).
  function automatic int pack_num(input int data_bit);
    return (2 * data_bit) / 8 + 1 + PERIOD_BYTES;
  endfunction

  function automatic logic [7:0] ctrl_byte(input logic [3:0] sel,
                                           input logic       start,
                                           input logic       stop,
                                           input logic       mode);
    logic [7:0] b;
    b = 8'h00;
    b[SEL_LSB +: SEL_W] = sel;
    b[START_BIT]        = start;
    b[STOP_BIT]         = stop;
    b[MODE_BIT]         = mode;
    return b;
  endfunction

endpackage

// File: rtl/frame_byte_sel.sv
// Combinational byte picker: returns byte[idx] of a flattened, LSB-byte-first frame.
// Out-of-range indices yield 8'h00.
module frame_byte_sel #(
  parameter int PACK_NUM = 9,
  parameter int IDX_W    = 4
) (
  input  logic [PACK_NUM*8-1:0] frame,
  input  logic [IDX_W-1:0]      idx,
  output logic [7:0]            data
);

  always_comb begin
    data = 8'h00;
    for (int i = 0; i < PACK_NUM; i++) begin
      if (idx == IDX_W'(i)) data = frame[i*8 +: 8];
    end
  end

endmodule

// File: rtl/diff_freq_frame_encoder.sv
// Serializes one channel configuration into the decoder's byte frame, one byte per
// transmitter handshake. Optional macro PERIOD_FIELD_EN appends slow/fast period bytes.
module diff_freq_frame_encoder
  import diff_freq_pkg::*;
#(
  parameter int DATA_BIT = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [DATA_BIT-1:0] i_output_pattern,
  input  logic [DATA_BIT-1:0] i_freq_pattern,
  input  logic [3:0]          i_sel_out,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_mode,
  input  logic [7:0]          i_slow_period,
  input  logic [7:0]          i_fast_period,
  output logic [7:0]          o_data,
  output logic                o_tx_start,
  input  logic                i_tx_done_tick,
  output logic                o_busy,
  output logic                o_done_tick
);

  localparam int PACK_NUM = pack_num(DATA_BIT);
  localparam int IDX_W    = $clog2(PACK_NUM);
  localparam int FRAME_W  = PACK_NUM * 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACK_NUM - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [FRAME_W-1:0] frame_q, frame_d, frame_cap;
  logic [7:0]         sel_byte;

`ifdef PERIOD_FIELD_EN
  assign frame_cap = {i_fast_period, i_slow_period,
                      ctrl_byte(i_sel_out, i_start, i_stop, i_mode),
                      i_freq_pattern, i_output_pattern};
`else
  // Period inputs exist only for port compatibility in this build.
  logic unused_period;
  assign unused_period = ^{i_slow_period, i_fast_period};
  assign frame_cap = {ctrl_byte(i_sel_out, i_start, i_stop, i_mode),
                      i_freq_pattern, i_output_pattern};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          frame_d = frame_cap;
          idx_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: state_d = S_WAIT;
      S_WAIT: begin
        if (i_tx_done_tick) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_SEND;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Select from the next-cycle frame/index so o_data is valid alongside o_tx_start.
  frame_byte_sel #(
    .PACK_NUM (PACK_NUM),
    .IDX_W    (IDX_W)
  ) u_byte_sel (
    .frame (frame_d),
    .idx   (idx_d),
    .data  (sel_byte)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
      idx_q   <= '0;
      o_data  <= 8'h00;
    end else begin
      frame_q <= frame_d;
      idx_q   <= idx_d;
      if (state_d == S_SEND) o_data <= sel_byte;
    end
  end

  assign o_ready     = (state_q == S_IDLE);
  assign o_busy      = (state_q != S_IDLE);
  assign o_tx_start  = (state_q == S_SEND);
  assign o_done_tick = (state_q == S_DONE);

endmodule

// File: tb/tb_diff_freq_frame_encoder.sv
// Directed bench for diff_freq_frame_encoder with a fixed-latency transmitter model.
module tb_diff_freq_frame_encoder;

`ifdef PERIOD_FIELD_EN
  localparam int PN = 11;
`else
  localparam int PN = 9;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_output_pattern = '0;
  logic [31:0] i_freq_pattern = '0;
  logic [3:0]  i_sel_out = '0;
  logic        i_start = 1'b0, i_stop = 1'b0, i_mode = 1'b0;
  logic [7:0]  i_slow_period = '0, i_fast_period = '0;
  logic [7:0]  o_data;
  logic        o_tx_start;
  logic        i_tx_done_tick;
  logic        o_busy;
  logic        o_done_tick;

  always #5 clk = ~clk;

  diff_freq_frame_encoder #(.DATA_BIT(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_valid          (i_valid),
    .o_ready          (o_ready),
    .i_output_pattern (i_output_pattern),
    .i_freq_pattern   (i_freq_pattern),
    .i_sel_out        (i_sel_out),
    .i_start          (i_start),
    .i_stop           (i_stop),
    .i_mode           (i_mode),
    .i_slow_period    (i_slow_period),
    .i_fast_period    (i_fast_period),
    .o_data           (o_data),
    .o_tx_start       (o_tx_start),
    .i_tx_done_tick   (i_tx_done_tick),
    .o_busy           (o_busy),
    .o_done_tick      (o_done_tick)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Transmitter model: done tick 10 cycles after each start, sampled on negedge.
  int         lat = 10;
  logic       model_tick = 1'b0;
  logic       spur_tick  = 1'b0;
  int         cnt = 0, cyc = 0, dones = 0, done_ok = 0;
  logic [7:0] bytes[$];
  int         start_cyc[$];
  int         tick_cyc[$];
  logic [7:0] exp_q[$];

  assign i_tx_done_tick = model_tick | spur_tick;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      cnt        = 0;
      model_tick = 1'b0;
    end else begin
      if (o_done_tick) begin
        dones++;
        if (model_tick) done_ok++;
      end
      model_tick = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          model_tick = 1'b1;
          tick_cyc.push_back(cyc);
        end
      end
      if (o_tx_start) begin
        cnt = lat;
        bytes.push_back(o_data);
        start_cyc.push_back(cyc);
      end
    end
  end

  task automatic clear_log();
    bytes.delete();
    start_cyc.delete();
    tick_cyc.delete();
    exp_q.delete();
    dones   = 0;
    done_ok = 0;
  endtask

  task automatic make_exp(input logic [31:0] outp, input logic [31:0] freq, input logic [3:0] sel,
                          input logic st, input logic sp, input logic md,
                          input logic [7:0] slow, input logic [7:0] fast);
    for (int b = 0; b < 4; b++) exp_q.push_back(outp[8*b +: 8]);
    for (int b = 0; b < 4; b++) exp_q.push_back(freq[8*b +: 8]);
    exp_q.push_back({1'b0, md, sp, st, sel});
`ifdef PERIOD_FIELD_EN
    exp_q.push_back(slow);
    exp_q.push_back(fast);
`else
    if (slow === 8'hxx && fast === 8'hxx) exp_q.push_back(8'h00);
`endif
  endtask

  // Returns #1 after the accepting edge (cycle k+1).
  task automatic send_cfg(input logic [31:0] outp, input logic [31:0] freq, input logic [3:0] sel,
                          input logic st, input logic sp, input logic md,
                          input logic [7:0] slow, input logic [7:0] fast);
    @(negedge clk);
    i_output_pattern = outp;
    i_freq_pattern   = freq;
    i_sel_out        = sel;
    i_start          = st;
    i_stop           = sp;
    i_mode           = md;
    i_slow_period    = slow;
    i_fast_period    = fast;
    i_valid          = 1'b1;
    for (int i = 0; i < 2000 && !o_ready; i++) @(negedge clk);
    if (!o_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: o_ready=%b required 1", o_ready);
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_dones(input int target);
    for (int i = 0; i < 3000 && dones < target; i++) begin
      @(negedge clk);
      #1;
    end
    n_checks++;
    if (dones < target) begin
      n_fail++;
      $display("FAIL frame_timeout: done ticks=%0d required %0d", dones, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (o_ready !== 1'b1)     begin n_fail++; $display("FAIL rst_ready: got %b want 1", o_ready); end
    n_checks++; if (o_busy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy: got %b want 0", o_busy); end
    n_checks++; if (o_tx_start !== 1'b0)  begin n_fail++; $display("FAIL rst_tx_start: got %b want 0", o_tx_start); end
    n_checks++; if (o_done_tick !== 1'b0) begin n_fail++; $display("FAIL rst_done_tick: got %b want 0", o_done_tick); end
    n_checks++; if (o_data !== 8'h00)     begin n_fail++; $display("FAIL rst_data: got %h want 00", o_data); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] want [0:8];
    want = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h0F, 8'h0F, 8'hA5, 8'hA5, 8'h53};
    clear_log();
    send_cfg(32'h11223344, 32'hA5A5_0F0F, 4'd3, 1'b1, 1'b0, 1'b1, 8'd9, 8'd3);
    n_checks++; if (o_tx_start !== 1'b1) begin n_fail++; $display("FAIL basic_start_latency: got %b want 1", o_tx_start); end
    n_checks++; if (o_data !== 8'h44)    begin n_fail++; $display("FAIL basic_first_byte: got %h want 44", o_data); end
    n_checks++; if (o_ready !== 1'b0)    begin n_fail++; $display("FAIL basic_ready_busy: got %b want 0", o_ready); end
    wait_dones(1);
    n_checks++; if (done_ok !== 1) begin n_fail++; $display("FAIL basic_done_timing: got %0d want 1", done_ok); end
    @(negedge clk); #1;
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_after: got %b want 1", o_ready); end
    n_checks++; if (bytes.size() != PN) begin n_fail++; $display("FAIL basic_start_count: got %0d want %0d", bytes.size(), PN); end
    for (int i = 0; i < 9 && i < bytes.size(); i++) begin
      n_checks++;
      if (bytes[i] !== want[i]) begin n_fail++; $display("FAIL basic_byte%0d: got %h want %h", i, bytes[i], want[i]); end
    end
    repeat (3) @(negedge clk);
    n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", dones); end
  endtask

`ifdef PERIOD_FIELD_EN
  task automatic test_period_fields();
    clear_log();
    send_cfg(32'h11223344, 32'hA5A5_0F0F, 4'd3, 1'b1, 1'b0, 1'b1, 8'd9, 8'd3);
    wait_dones(1);
    n_checks++; if (bytes.size() != 11) begin n_fail++; $display("FAIL period_count: got %0d want 11", bytes.size()); end
    n_checks++; if (bytes[9] !== 8'h09)  begin n_fail++; $display("FAIL period_slow: got %h want 09", bytes[9]); end
    n_checks++; if (bytes[10] !== 8'h03) begin n_fail++; $display("FAIL period_fast: got %h want 03", bytes[10]); end
    repeat (3) @(negedge clk);
  endtask
`endif

  task automatic test_back_to_back();
    int early;
    clear_log();
    make_exp(32'h0BADF00D, 32'h1357_9BDF, 4'd7, 1'b1, 1'b1, 1'b0, 8'd20, 8'd5);
    make_exp(32'hCAFEBABE, 32'h0123_4567, 4'd12, 1'b0, 1'b1, 1'b0, 8'd40, 8'd2);
    send_cfg(32'h0BADF00D, 32'h1357_9BDF, 4'd7, 1'b1, 1'b1, 1'b0, 8'd20, 8'd5);
    i_output_pattern = 32'hCAFEBABE;
    i_freq_pattern   = 32'h0123_4567;
    i_sel_out        = 4'd12;
    i_start          = 1'b0;
    i_stop           = 1'b1;
    i_mode           = 1'b0;
    i_slow_period    = 8'd40;
    i_fast_period    = 8'd2;
    i_valid          = 1'b1;
    early = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (o_ready) begin
        if (dones == 0) early = 1;
        break;
      end
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    n_checks++; if (early !== 0) begin n_fail++; $display("FAIL b2b_ready_during_frame: got %0d want 0", early); end
    wait_dones(2);
    n_checks++; if (bytes.size() != 2*PN) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", bytes.size(), 2*PN); end
    for (int i = 0; i < 2*PN && i < bytes.size(); i++) begin
      n_checks++;
      if (bytes[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_byte%0d: got %h want %h", i, bytes[i], exp_q[i]); end
    end
    if (start_cyc.size() > PN && tick_cyc.size() >= PN) begin
      n_checks++;
      if (start_cyc[PN] - tick_cyc[PN-1] != 3) begin
        n_fail++;
        $display("FAIL b2b_gap: got %0d cycles want 3", start_cyc[PN] - tick_cyc[PN-1]);
      end
    end else begin
      n_checks++; n_fail++;
      $display("FAIL b2b_gap: got %0d starts want more than %0d", start_cyc.size(), PN);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_spurious();
    clear_log();
    make_exp(32'h89AB_CDEF, 32'hF0F0_3C3C, 4'd9, 1'b0, 1'b0, 1'b1, 8'd7, 8'd1);
    @(negedge clk); spur_tick = 1'b1;
    @(negedge clk); spur_tick = 1'b0;
    #1;
    n_checks++; if (o_busy !== 1'b0)     begin n_fail++; $display("FAIL spur_idle_busy: got %b want 0", o_busy); end
    n_checks++; if (o_tx_start !== 1'b0) begin n_fail++; $display("FAIL spur_idle_start: got %b want 0", o_tx_start); end
    send_cfg(32'h89AB_CDEF, 32'hF0F0_3C3C, 4'd9, 1'b0, 1'b0, 1'b1, 8'd7, 8'd1);
    spur_tick = 1'b1;
    @(posedge clk); #1;
    spur_tick = 1'b0;
    wait_dones(1);
    n_checks++; if (bytes.size() != PN) begin n_fail++; $display("FAIL spur_count: got %0d want %0d", bytes.size(), PN); end
    for (int i = 0; i < PN && i < bytes.size(); i++) begin
      n_checks++;
      if (bytes[i] !== exp_q[i]) begin n_fail++; $display("FAIL spur_byte%0d: got %h want %h", i, bytes[i], exp_q[i]); end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    clear_log();
    send_cfg(32'h5566_7788, 32'h99AA_BBCC, 4'd1, 1'b1, 1'b0, 1'b0, 8'd3, 8'd4);
    for (int i = 0; i < 2000 && bytes.size() < 4; i++) begin @(negedge clk); #1; end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (o_ready !== 1'b1)     begin n_fail++; $display("FAIL mid_rst_ready: got %b want 1", o_ready); end
    n_checks++; if (o_busy !== 1'b0)      begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", o_busy); end
    n_checks++; if (o_tx_start !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_start: got %b want 0", o_tx_start); end
    n_checks++; if (o_done_tick !== 1'b0) begin n_fail++; $display("FAIL mid_rst_done: got %b want 0", o_done_tick); end
    n_checks++; if (o_data !== 8'h00)     begin n_fail++; $display("FAIL mid_rst_data: got %h want 00", o_data); end
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL mid_rst_no_done: got %0d want 0", dones); end
    clear_log();
    make_exp(32'h0102_0304, 32'h0506_0708, 4'd15, 1'b1, 1'b1, 1'b1, 8'd11, 8'd12);
    send_cfg(32'h0102_0304, 32'h0506_0708, 4'd15, 1'b1, 1'b1, 1'b1, 8'd11, 8'd12);
    wait_dones(1);
    n_checks++; if (bytes.size() != PN) begin n_fail++; $display("FAIL post_rst_count: got %0d want %0d", bytes.size(), PN); end
    for (int i = 0; i < PN && i < bytes.size(); i++) begin
      n_checks++;
      if (bytes[i] !== exp_q[i]) begin n_fail++; $display("FAIL post_rst_byte%0d: got %h want %h", i, bytes[i], exp_q[i]); end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_input_change();
    clear_log();
    make_exp(32'h2468_ACE0, 32'h1122_3344, 4'd5, 1'b0, 1'b1, 1'b1, 8'd6, 8'd2);
    send_cfg(32'h2468_ACE0, 32'h1122_3344, 4'd5, 1'b0, 1'b1, 1'b1, 8'd6, 8'd2);
    i_output_pattern = 32'hDEAD_BEEF;
    i_freq_pattern   = 32'hFFFF_0000;
    i_sel_out        = 4'd0;
    i_mode           = 1'b0;
    i_slow_period    = 8'hEE;
    wait_dones(1);
    n_checks++; if (bytes.size() != PN) begin n_fail++; $display("FAIL chg_count: got %0d want %0d", bytes.size(), PN); end
    for (int i = 0; i < PN && i < bytes.size(); i++) begin
      n_checks++;
      if (bytes[i] !== exp_q[i]) begin n_fail++; $display("FAIL chg_byte%0d: got %h want %h", i, bytes[i], exp_q[i]); end
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
`ifdef PERIOD_FIELD_EN
    test_period_fields();
`endif
    test_back_to_back();
    test_spurious();
    test_reset_mid();
    test_input_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
